// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and one-hot decode helper for the one-hot register file
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   // Upper bound on select width the helper can decode; callers zero-extend into it.
   localparam int MAX_DEPTH = 256;

   // Returns 1 when exactly one of the low `depth` bits is set; idx is MSB-first (bit depth-1 = entry 0).
   function automatic logic onehot_to_idx(input logic [MAX_DEPTH-1:0] sel, input int depth, output int idx);
      int count;
      count = 0;
      idx   = 0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
         if (i < depth && sel[i]) begin
            count++;
            idx = depth - 1 - i;
         end
      end
      return (count == 1);
   endfunction

endpackage

// File: rtl/onehot_regfile_if.sv
// rtl/onehot_regfile_if.sv - write/read/control bus of the one-hot register file
interface onehot_regfile_if #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
);
   logic             we;
   logic [DEPTH-1:0] wsel;
   logic [WIDTH-1:0] wdata;
   logic [DEPTH-1:0] rsel_a;
   logic [DEPTH-1:0] rsel_b;
   logic [WIDTH-1:0] rdata_a;
   logic [WIDTH-1:0] rdata_b;
   logic             clr_req;
   logic             busy;
   logic             err_clr;
   logic             sel_err;

   modport master (
      output we, wsel, wdata, rsel_a, rsel_b, clr_req, err_clr,
      input  rdata_a, rdata_b, busy, sel_err
   );

   modport slave (
      input  we, wsel, wdata, rsel_a, rsel_b, clr_req, err_clr,
      output rdata_a, rdata_b, busy, sel_err
   );
endinterface

// File: rtl/onehot_decode.sv
// rtl/onehot_decode.sv - one-hot select to index decoder with zero/multi-hot flags
module onehot_decode
   import regfile_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic [DEPTH-1:0]                          sel,
   output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] idx,
   output logic                                      zero,
   output logic                                      multi
);
   localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [MAX_DEPTH-1:0] selWide;
   logic                 valid;
   int                   idxInt;

   assign selWide = MAX_DEPTH'(sel);

   always_comb begin
      idxInt = 0;
      valid  = onehot_to_idx(selWide, DEPTH, idxInt);
      idx    = IDXW'(idxInt);
      zero   = ~|sel;
      multi  = !valid && !zero;
   end
endmodule

// File: rtl/onehot_regfile.sv
// rtl/onehot_regfile.sv - one-hot selected register file, 1 write / 2 registered read ports
// Includes sticky select-error flag and a sequencer that zeroes the array one entry per cycle.
module onehot_regfile
   import regfile_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   onehot_regfile_if.slave bus
);
   localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [IDXW-1:0]  wIdx, aIdx, bIdx;
   logic             wZero, wMulti, aZero, aMulti, bZero, bMulti;
   state_t           state, stateNext;
   logic [IDXW-1:0]  clrCnt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdataA, rdataB;
   logic             selErr;
   logic             idle, wValid, doWrite, clrDone, errSet;

   onehot_decode #(.DEPTH(DEPTH)) uDecW (.sel(bus.wsel),   .idx(wIdx), .zero(wZero), .multi(wMulti));
   onehot_decode #(.DEPTH(DEPTH)) uDecA (.sel(bus.rsel_a), .idx(aIdx), .zero(aZero), .multi(aMulti));
   onehot_decode #(.DEPTH(DEPTH)) uDecB (.sel(bus.rsel_b), .idx(bIdx), .zero(bZero), .multi(bMulti));

   assign idle    = (state == IDLE);
   assign wValid  = !wZero && !wMulti;
   assign doWrite = idle && bus.we && wValid;
   assign clrDone = (clrCnt == IDXW'(DEPTH - 1));
   // Select errors only count while the array is externally accessible.
   assign errSet  = idle && ((bus.we && !wValid) || aMulti || bMulti);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (bus.clr_req) stateNext = CLEAR;
         CLEAR:   if (clrDone)     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                clrCnt <= '0;
      else if (state == CLEAR) clrCnt <= clrDone ? '0 : clrCnt + 1'b1;
      else                    clrCnt <= '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (state == CLEAR) begin
         mem[clrCnt] <= '0;
      end else if (doWrite) begin
         mem[wIdx] <= bus.wdata;
      end
   end

   // Write-first: a read of the entry being written returns the new data.
   function automatic logic [WIDTH-1:0] readPort(input logic [IDXW-1:0] idx, input logic zero, input logic multi);
      if (zero || multi)             return '0;
      else if (doWrite && wIdx == idx) return bus.wdata;
      else                           return mem[idx];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdataA <= '0;
         rdataB <= '0;
      end else if (!idle) begin
         rdataA <= '0;
         rdataB <= '0;
      end else begin
         rdataA <= readPort(aIdx, aZero, aMulti);
         rdataB <= readPort(bIdx, bZero, bMulti);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              selErr <= 1'b0;
      else if (errSet)      selErr <= 1'b1;
      else if (bus.err_clr) selErr <= 1'b0;
   end

   assign bus.rdata_a = rdataA;
   assign bus.rdata_b = rdataB;
   assign bus.busy    = (state == CLEAR);
   assign bus.sel_err = selErr;
endmodule

// File: tb/tb_onehot_regfile.sv
// tb/tb_onehot_regfile.sv - scoreboard bench for onehot_regfile
module tb_onehot_regfile;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   onehot_regfile_if #(.DEPTH(16), .WIDTH(8)) bus ();
   onehot_regfile #(.DEPTH(16), .WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      string      name;
      logic [7:0] a;
      logic [7:0] b;
   } exp_t;

   exp_t sbq[$];
   logic issue = 1'b0;
   int   nChecks = 0;
   int   nFail = 0;
   int   busyCnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.we = 1'b0; bus.wsel = '0; bus.wdata = '0;
      bus.rsel_a = '0; bus.rsel_b = '0; bus.clr_req = 1'b0; bus.err_clr = 1'b0;
   endtask

   task automatic wr(input int idx, input logic [7:0] d);
      bus.we = 1'b1; bus.wsel = 16'h8000 >> idx; bus.wdata = d;
      tick();
      bus.we = 1'b0; bus.wsel = '0;
   endtask

   task automatic expect_rd(input string name, input logic [7:0] ea, input logic [7:0] eb);
      exp_t e;
      e.name = name; e.a = ea; e.b = eb;
      sbq.push_back(e);
      issue = 1'b1;
   endtask

   task automatic rd(input string name, input logic [15:0] sa, input logic [15:0] sb,
                     input logic [7:0] ea, input logic [7:0] eb);
      bus.rsel_a = sa; bus.rsel_b = sb;
      expect_rd(name, ea, eb);
      tick();
      issue = 1'b0; bus.rsel_a = '0; bus.rsel_b = '0;
   endtask

   task automatic pulse_err_clr();
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
   endtask

   initial begin : monitor
      logic hit;
      exp_t e;
      forever begin
         @(posedge clk);
         hit = issue;
         @(negedge clk);
         if (hit) begin
            if (sbq.size() == 0) begin
               check("sb_underflow", 1, 0);
            end else begin
               e = sbq.pop_front();
               check({e.name, "_a"}, 32'(bus.rdata_a), 32'(e.a));
               check({e.name, "_b"}, 32'(bus.rdata_b), 32'(e.b));
            end
         end
      end
   end

   initial begin
      quiet();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_sel_err", 32'(bus.sel_err), 0);
      check("rst_rdata_a", 32'(bus.rdata_a), 0);
      for (int i = 0; i < 16; i++)
         rd($sformatf("rst_rd%0d", i), 16'h8000 >> i, 16'h8000 >> i, 8'h00, 8'h00);

      wr(0, 8'hA5);
      rd("rd_entry0", 16'h8000, 16'h0000, 8'hA5, 8'h00);

      // Same-cycle write and read of entry 15: read returns the new data.
      bus.we = 1'b1; bus.wsel = 16'h0001; bus.wdata = 8'h3C; bus.rsel_b = 16'h0001;
      expect_rd("bypass", 8'h00, 8'h3C);
      tick();
      issue = 1'b0; quiet();
      rd("after_bypass", 16'h0001, 16'h0000, 8'h3C, 8'h00);

      bus.we = 1'b1; bus.wsel = 16'h0003; bus.wdata = 8'h77;
      tick();
      quiet();
      check("bad_wr_err", 32'(bus.sel_err), 1);
      rd("bad_wr_nochange", 16'h0001, 16'h0002, 8'h3C, 8'h00);
      pulse_err_clr();
      check("err_clr", 32'(bus.sel_err), 0);
      bus.we = 1'b1; bus.wsel = 16'h0003; bus.wdata = 8'h77; bus.err_clr = 1'b1;
      tick();
      quiet();
      check("err_set_wins", 32'(bus.sel_err), 1);
      pulse_err_clr();
      check("err_clr2", 32'(bus.sel_err), 0);
      rd("multi_rd", 16'h0300, 16'h8000, 8'h00, 8'hA5);
      check("multi_rd_err", 32'(bus.sel_err), 1);
      pulse_err_clr();
      rd("idle_port", 16'h0000, 16'h0001, 8'h00, 8'h3C);
      check("idle_port_noerr", 32'(bus.sel_err), 0);

      for (int i = 0; i < 16; i++) wr(i, 8'hFF);
      rd("filled", 16'h0100, 16'h0001, 8'hFF, 8'hFF);
      bus.we = 1'b1; bus.wsel = 16'h8000; bus.wdata = 8'h11; bus.clr_req = 1'b1;
      tick();
      quiet();
      busyCnt = 0;
      while (bus.busy && busyCnt < 40) begin
         busyCnt++;
         bus.we = 1'b1; bus.wsel = 16'h8000; bus.wdata = 8'h5A; bus.clr_req = 1'b1;
         bus.rsel_a = 16'h8000; bus.rsel_b = 16'hFFFF;
         expect_rd($sformatf("clr_rd%0d", busyCnt), 8'h00, 8'h00);
         tick();
         issue = 1'b0;
      end
      quiet();
      check("busy_cycles", 32'(busyCnt), 16);
      check("clr_noerr", 32'(bus.sel_err), 0);
      for (int i = 0; i < 16; i++)
         rd($sformatf("post_clr%0d", i), 16'h8000 >> i, 16'h8000 >> i, 8'h00, 8'h00);

      for (int i = 0; i < 16; i++) wr(i, 8'hFF);
      bus.clr_req = 1'b1;
      tick();
      bus.clr_req = 1'b0;
      repeat (4) tick();
      check("mid_clr_busy", 32'(bus.busy), 1);
      rst = 1'b1;
      #1;
      check("rst_abort_busy", 32'(bus.busy), 0);
      tick();
      rst = 1'b0;
      tick();
      check("rst_abort_idle", 32'(bus.busy), 0);
      for (int i = 0; i < 16; i++)
         rd($sformatf("post_rst%0d", i), 16'h8000 >> i, 16'h8000 >> i, 8'h00, 8'h00);
      wr(3, 8'h42);
      rd("new_wr", 16'h1000, 16'h0001, 8'h42, 8'h00);

      tick();
      tick();
      check("sb_drain", 32'(sbq.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule
